// File: rtl/prng_pkg.sv
// Shared defaults, FSM state type and sizing helper for the PRNG word collector.
package prng_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int WARMUP_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_WARM    = 2'd2,
    ST_COLLECT = 2'd3
  } state_e;

  // Bits needed to index n items; never less than one so counters stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_word_fifo.sv
// Small word FIFO with occupancy count; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module prng_word_fifo
  import prng_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rdata is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/prng_word_collector.sv
// Seeds the dual-CLCG generator, skips its warm-up bits, then packs the bit
// stream MSB-first into words that are queued for a ready/valid consumer.
module prng_word_collector
  import prng_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              bit_in,
  output logic              gen_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              overflow
);

  localparam int BCW = cnt_width(WORD_W);
  localparam int WCW = cnt_width(WARMUP);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e            state_q, state_d;
  logic [WCW-1:0]    warm_cnt_q, warm_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  // SEED always runs its single cycle; en is only honoured from WARM onwards.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (en) state_d = ST_SEED;
      ST_SEED:    state_d = (WARMUP == 0) ? ST_COLLECT : ST_WARM;
      ST_WARM: begin
        if (!en)                          state_d = ST_IDLE;
        else if (warm_cnt_q == WARM_LAST) state_d = ST_COLLECT;
      end
      ST_COLLECT: if (!en) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gen_start = (state_q == ST_SEED);
  end

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    case (state_q)
      ST_WARM: begin
        if (en && warm_cnt_q != WARM_LAST) warm_cnt_d = warm_cnt_q + WCW'(1);
        else                               warm_cnt_d = '0;
      end
      ST_COLLECT: begin
        if (en) begin
          shift_d = {shift_q[WORD_W-2:0], bit_in};
          if (bit_cnt_q == BIT_LAST) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      default: begin
        warm_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
      end
    endcase
  end

  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign overflow_d = overflow_q | (push & fifo_full & ~pop);
  assign overflow   = overflow_q;

  prng_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (shift_d),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_prng_word_collector.sv
// Randomized bench for prng_word_collector with a cycle-level reference model
// built from seed age, a word queue and a sticky drop flag.
module tb_prng_word_collector;

  localparam int WORD_W = 16;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 8;
  localparam int VW     = WORD_W + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              bit_in;
  logic              out_ready;
  logic              gen_start;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                m_active;
  int                m_age;
  logic [WORD_W-1:0] m_word;
  logic [WORD_W-1:0] q[$];
  bit                m_ovf;

  prng_word_collector #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .WARMUP (WARMUP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bit_in    (bit_in),
    .gen_start (gen_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] obs = {gen_start, out_valid, overflow, out_data};

  function automatic logic [VW-1:0] exp_vec();
    logic [WORD_W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    return {(m_active && m_age == 0), (q.size() > 0), m_ovf, head};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_age    = 0;
    m_word   = '0;
    q.delete();
    m_ovf    = 0;
  endtask

  // Age 0 is the seed cycle, ages 1..WARMUP are discarded, later ages are data bits.
  task automatic model_step(input bit e, input bit b, input bit r);
    bit                pop;
    bit                push;
    logic [WORD_W-1:0] pw;
    pop  = (q.size() > 0) && r;
    push = 0;
    pw   = '0;
    if (!m_active) begin
      if (e) begin
        m_active = 1;
        m_age    = 0;
        m_word   = '0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (!e) begin
      m_active = 0;
    end else begin
      if (m_age > WARMUP) begin
        m_word = {m_word[WORD_W-2:0], b};
        if ((m_age - 1 - WARMUP) % WORD_W == WORD_W - 1) begin
          push = 1;
          pw   = m_word;
        end
      end
      m_age++;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(pw);
      else m_ovf = 1;
    end
  endtask

  function automatic bit will_complete();
    return m_active && m_age > WARMUP && ((m_age - 1 - WARMUP) % WORD_W == WORD_W - 1);
  endfunction

  // Called at a negedge; returns at the next negedge with model updated.
  task automatic tick(input bit e, input bit b, input bit r);
    en        = e;
    bit_in    = b;
    out_ready = r;
    model_step(e, b, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 0; bit_in = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; bit_in = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, {VW{1'b0}});
    end
    rst_n = 1'b1;
    model_reset();
    tick(0, 0, 0);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_basic_word();
    int gs = 0;
    for (int i = 0; i < 2 + WARMUP + WORD_W; i++) begin
      bit b;
      b = (i < 2 + WARMUP) ? 1'($urandom) : ((i - 2 - WARMUP) % 2 == 0);
      tick(1, b, 0);
      if (gen_start) gs++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (gs != 1) begin
      errors++;
      $display("FAIL basic_gen_start_cycles: got %0d expected 1", gs);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL basic_word: got valid=%b data=%h expected valid=1 data=aaaa", out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4 * WORD_W; i++) begin
      tick(1, 1'($urandom), 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_fill%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b expected 1", overflow);
    end
    checks++;
    if (out_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL ovf_head: got %h expected aaaa", out_data);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick(0, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain: got valid=%b ovf=%b expected valid=0 ovf=1", out_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    bit hit = 0;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 200 && !hit; i++) begin
      bit r;
      r = (q.size() == DEPTH) && will_complete();
      hit = r;
      tick(1, 1'($urandom), r);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL fullpop_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL fullpop_timeout: got no full-and-complete cycle expected one");
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_overflow: got %b expected 0", overflow);
    end
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (out_valid) pops++;
      tick(0, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL fullpop_drain%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (pops != DEPTH) begin
      errors++;
      $display("FAIL fullpop_count: got %0d words expected %0d", pops, DEPTH);
    end
  endtask

  task automatic test_abort_reseed();
    logic [WORD_W-1:0] fresh = '0;
    int gs = 0;
    do_reset();
    for (int i = 0; i < 2 + WARMUP + 7; i++) tick(1, 1'($urandom), 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1'($urandom), 0);
      checks++;
      if (obs !== exp_vec() || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 2 + WARMUP + WORD_W; i++) begin
      bit b;
      b = 1'($urandom);
      if (i >= 2 + WARMUP) fresh = {fresh[WORD_W-2:0], b};
      tick(1, b, 0);
      if (gen_start) gs++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL abort_reseed%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (gs != 1 || out_valid !== 1'b1 || out_data !== fresh) begin
      errors++;
      $display("FAIL abort_fresh_word: got gs=%0d valid=%b data=%h expected gs=1 valid=1 data=%h",
               gs, out_valid, out_data, fresh);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2 + WARMUP + 2 * WORD_W + 5; i++) tick(1, 1'($urandom), 0);
    checks++;
    if (q.size() != 2 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL midrst_pre: got %h expected %h with 2 words", obs, exp_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gen_start !== 1'b0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL midrst_async: got gs=%b valid=%b ovf=%b data=%h expected all 0",
               gen_start, out_valid, overflow, out_data);
    end
    en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(0, 0, 0);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL midrst_after: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_stream();
    int words = 0;
    int last  = -1;
    int gap_bad = 0;
    do_reset();
    for (int i = 0; i < 2 + WARMUP + 5 * WORD_W; i++) begin
      tick(1, 1, 1);
      if (out_valid) begin
        words++;
        if (out_data !== 16'hFFFF) gap_bad++;
        if (last >= 0 && i - last != WORD_W) gap_bad++;
        last = i;
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL stream_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (words != 5 || gap_bad != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_summary: got words=%0d bad=%0d ovf=%b expected words=5 bad=0 ovf=0",
               words, gap_bad, overflow);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom));
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_word();
    test_overflow();
    test_full_pop();
    test_abort_reseed();
    test_reset_mid();
    test_stream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_word_collector.md
PRNG_WORD_COLLECTOR -- requirements
Module: prng_word_collector

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning output word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of output FIFO entries (power of 2).
REQ-003 SHALL have parameter WARMUP, default 8, meaning number of generator bits discarded after each seed.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  level enable; 1 requests word generation.
REQ-007 SHALL have port bit_in  input  1  random bit Zi from the dual-CLCG generator, one new bit per clk.
REQ-008 SHALL have port gen_start  output  1  drives the generator start input (seed load).
REQ-009 SHALL have port out_valid  output  1  FIFO head holds a word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head word when out_valid=1.
REQ-011 SHALL have port out_data  output  WORD_W  FIFO head word.
REQ-012 SHALL have port overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 SHALL implement FSM states IDLE, SEED, WARM, COLLECT.
REQ-014 SHALL go IDLE->SEED when en=1; SEED lasts exactly 1 cycle with gen_start=1; gen_start SHALL be 0 in all other states.
REQ-015 SHALL go SEED->WARM, discard exactly WARMUP bit_in samples (one per cycle), then enter COLLECT; WARMUP=0 goes SEED->COLLECT directly.
REQ-016 SHALL in COLLECT sample bit_in every cycle, shifting MSB-first (first collected bit ends in out_data[WORD_W-1]).
REQ-017 SHALL on the WORD_W-th collected bit push the assembled word (including that bit) into the FIFO in the same cycle, clear the bit count, and continue collecting without gap.
REQ-018 SHALL when en=0 in WARM or COLLECT return to IDLE next cycle, discard the partial word and bit count, and retain FIFO contents; bit_in on that cycle is ignored.
REQ-019 SHALL treat a pop as out_valid & out_ready; head advances next cycle.
REQ-020 SHALL accept a push when FIFO not full, or when full and a pop occurs in the same cycle.
REQ-021 SHALL drop a push when full with no same-cycle pop, and set overflow=1; overflow clears only on reset.
REQ-022 SHALL make a pushed word visible as out_valid/out_data on the cycle after the push (1-cycle latency into an empty FIFO).
REQ-023 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH, with full/empty from an occupancy count 0..DEPTH.
REQ-025 SHALL let en toggling 0->1 re-seed via SEED and WARM every time.

Reset
REQ-026 SHALL on rst_n=0, asynchronously: state=IDLE, gen_start=0, out_valid=0, out_data=0, overflow=0, FIFO count/pointers=0, shift register and bit count=0.
REQ-027 SHALL resume from IDLE on the first rising clk edge after rst_n deasserts; reset mid-word discards the partial word and all FIFO contents.

Structure
REQ-028 SHALL place WORD_W/DEPTH/WARMUP defaults and the FSM state enum in shared package prng_pkg.
REQ-029 SHALL implement the buffer as sub-module prng_word_fifo (push/pop/full/empty/count, async active-low reset); FSM and shift register stay in the top.

Verification
REQ-030 SHALL cover reset then en=1 held: gen_start high exactly 1 cycle, 8 bits ignored, bit_in pattern 1010... for 16 cycles -> out_data=16'hAAAA, out_valid 1 cycle after 16th bit.
REQ-031 SHALL cover out_ready=0 and 5 words collected -> 4 words held, overflow=1, first 4 words read out in order once out_ready=1.
REQ-032 SHALL cover FIFO full and out_ready=1 in the cycle a 5th word completes -> no drop, overflow stays 0, count stays 4.
REQ-033 SHALL cover en=0 after 7 collected bits -> IDLE, no push; en=1 again -> new 1-cycle gen_start, 8 warm-up bits, fresh word.
REQ-034 SHALL cover rst_n=0 asserted mid-COLLECT between edges with 2 words buffered -> out_valid=0, overflow=0, gen_start=0 immediately.
REQ-035 SHALL cover out_ready=1 held, continuous bit_in=1 -> 16'hFFFF every 16 cycles, no gaps, no overflow.
